enc_stim_ctrl: RTL and testbench
================================

# enc_stim_ctrl

Sequencer for the encoder test stimulus path. It produces a quadrature A/B pair with a programmable edge spacing, direction and edge count, under a start/busy/done handshake. It also keeps a signed model position so a bench or the DSP can cross-check the encoder decoder under test. It sits between the register/control interface and the encoder input pins of the decoder being exercised.

## Interface
- WIDTH, 32, width of half_period and of the edge-spacing timer
- STEP_W, 16, width of the steps request and the remaining-step counter
- POS_W, 32, width of the signed model position

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  terminate a run; stops all further edges
- dir  in  1  1 = forward (A leads B), 0 = reverse (B leads A); latched on start
- half_period  in  WIDTH  clk cycles between successive quadrature edges; latched on start; 0 is treated as 1
- steps  in  STEP_W  number of quadrature edges (quarter counts) to emit; latched on start
- clr_pos  in  1  synchronous clear of pos
- quad_a  out  1  encoder channel A, registered
- quad_b  out  1  encoder channel B, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at the end of a completed or aborted run
- pos  out  POS_W  signed model position, two's complement

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and abort=0: latch dir, half_period (0→1) and steps, clear the timer, go to RUN.
  - If start and abort are both 1 in IDLE, abort wins and no run starts.
- RUN:
  - The timer counts 0..hp-1.
  - At hp-1 the timer wraps, the phase advances one step, remaining decrements and pos moves ±1.
  - When remaining reaches 0 after a step, go to DONE.
  - If steps=0 at latch, go straight from RUN to DONE after one cycle with no edge.
- Abort in RUN: go to DONE on the next edge. If abort coincides with a timer wrap, the abort wins and no step is emitted. quad_a/quad_b hold their current levels.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE and in RUN.
- Phase {A,B}:
  - Forward: 00→10→11→01→00.
  - Reverse: 00→01→11→10→00.
  - The phase persists across runs, so a new run continues from the last levels.
  - Exactly one output toggles per step.
- pos:
  - Wraps modulo 2^POS_W.
  - clr_pos sets pos to 0. If clr_pos coincides with a step, the clear wins and the result is 0.
- Reset values: quad_a=0, quad_b=0, busy=0, done=0, pos=0, state IDLE, timer 0, remaining 0.
- Reset mid-run returns immediately to the reset values; no done pulse is produced.

## Timing
- start accepted at edge N: busy=1 from N+1 through the last RUN cycle.
- First output edge is visible at N+hp. Step k (1-based) is visible at N+k·hp.
- done is high in the cycle after the last step becomes visible; busy=0 in that same cycle.
- Run of steps=S with half-period hp: exactly S toggles in total, uniformly spaced hp cycles apart.
- Full quadrature cycle (4 steps) = 4·hp clk.
- Back-to-back runs: the earliest next start is accepted in the cycle after the done pulse, in IDLE.
- pos updates in the same cycle as the corresponding output toggle.

## Structure
- Package enc_stim_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the 2-bit phase constants and the forward/reverse next-phase functions;
  - default widths.
- Sub-module enc_stim_timer: loadable WIDTH-bit half-period counter with clear input and a one-cycle wrap pulse output.
- The top level holds the FSM, remaining counter, phase register and pos accumulator.

## Test plan
- Forward run: hp=3, steps=8, dir=1 from reset → A/B sequence 10,11,01,00,10,11,01,00; edges at N+3,6,…,24; pos=+8; done at N+25.
- Reverse run: hp=1, steps=5, starting from the forward end state 00 → 01,11,10,00,01; pos decrements by 5; one edge per cycle.
- Boundary inputs:
  - steps=0 → no toggles, busy for 1 cycle, done pulse, pos unchanged.
  - hp=0 → behaves identically to hp=1.
- Abort after 3 of 10 steps (hp=4), with abort asserted on a wrap cycle → 3 toggles only, levels held, done one cycle later; a start during RUN is ignored.
- Simultaneous events:
  - clr_pos on a step cycle → pos=0.
  - start+abort in IDLE → no run.
  - pos at 2^31−1 plus one forward step → −2^31.
- Async reset mid-run → all outputs return to 0 immediately, no done pulse; the next start runs normally.

Source files
------------

// File: rtl/enc_stim_pkg.sv
// Shared types, quadrature phase constants and default widths for the
// encoder stimulus sequencer.
package enc_stim_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STEP_W = 16;
   localparam int DEF_POS_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Phase encoding is {A,B}
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   function automatic logic [1:0] next_fwd(input logic [1:0] ph);
      logic [1:0] nxt;
      nxt = PH_00;
      case (ph)
         PH_00:   nxt = PH_10;
         PH_10:   nxt = PH_11;
         PH_11:   nxt = PH_01;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

   function automatic logic [1:0] next_rev(input logic [1:0] ph);
      logic [1:0] nxt;
      nxt = PH_00;
      case (ph)
         PH_00:   nxt = PH_01;
         PH_01:   nxt = PH_11;
         PH_11:   nxt = PH_10;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/enc_stim_timer.sv
// Edge-spacing timer: counts 0..limit while enabled and flags the wrap cycle.
// A loaded half-period of 0 is stored as limit 0, i.e. the same as 1.
module enc_stim_timer
   import enc_stim_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] half_period,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         limit <= '0;
      end else begin
         if (load) begin
            limit <= (half_period == '0) ? '0 : half_period - ONE;
         end
         if (clear) begin
            count <= '0;
         end else if (enable) begin
            count <= (count == limit) ? '0 : count + ONE;
         end
      end
   end

   assign wrap = enable && (count == limit);

endmodule

// File: rtl/enc_stim_ctrl.sv
// Quadrature A/B stimulus sequencer with start/busy/done handshake and a
// signed model position that tracks every emitted edge.
module enc_stim_ctrl
   import enc_stim_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W,
   parameter int POS_W  = DEF_POS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              dir,
   input  logic [WIDTH-1:0]  half_period,
   input  logic [STEP_W-1:0] steps,
   input  logic              clr_pos,
   output logic              quad_a,
   output logic              quad_b,
   output logic              busy,
   output logic              done,
   output logic [POS_W-1:0]  pos
);

   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

   state_t            state;
   logic [1:0]        phase;
   logic [STEP_W-1:0] remaining;
   logic              dir_r;
   logic              start_run;
   logic              wrap;

   assign start_run = (state == IDLE) && start && !abort;

   enc_stim_timer #(
      .WIDTH(WIDTH)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_run),
      .clear      (start_run),
      .enable     (state == RUN),
      .half_period(half_period),
      .wrap       (wrap)
   );

   // Abort takes priority over a coincident wrap so no edge escapes; the
   // position clear is applied last so it also beats a coincident step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= PH_00;
         remaining <= '0;
         dir_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pos       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_run) begin
                  dir_r     <= dir;
                  remaining <= steps;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (abort || remaining == '0) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end else if (wrap) begin
                  phase     <= dir_r ? next_fwd(phase) : next_rev(phase);
                  remaining <= remaining - STEP_ONE;
                  pos       <= dir_r ? pos + POS_ONE : pos - POS_ONE;
                  if (remaining == STEP_ONE) begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (clr_pos) begin
            pos <= '0;
         end
      end
   end

   assign quad_a = phase[1];
   assign quad_b = phase[0];

endmodule

// File: tb/tb_enc_stim_ctrl.sv
// Directed bench for enc_stim_ctrl; a narrow second instance exercises the
// signed position overflow at a reachable width.
module tb_enc_stim_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        dir;
   logic [31:0] half_period;
   logic [15:0] steps;
   logic        clr_pos;
   logic        quad_a;
   logic        quad_b;
   logic        busy;
   logic        done;
   logic [31:0] pos;

   logic        quad_a_w;
   logic        quad_b_w;
   logic        busy_w;
   logic        done_w;
   logic [3:0]  pos_w;

   int          n_compared;
   int          n_mismatched;
   logic [1:0]  exp_q[$];

   enc_stim_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .dir        (dir),
      .half_period(half_period),
      .steps      (steps),
      .clr_pos    (clr_pos),
      .quad_a     (quad_a),
      .quad_b     (quad_b),
      .busy       (busy),
      .done       (done),
      .pos        (pos)
   );

   enc_stim_ctrl #(
      .WIDTH (8),
      .STEP_W(4),
      .POS_W (4)
   ) dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .dir        (dir),
      .half_period(half_period[7:0]),
      .steps      (steps[3:0]),
      .clr_pos    (clr_pos),
      .quad_a     (quad_a_w),
      .quad_b     (quad_b_w),
      .busy       (busy_w),
      .done       (done_w),
      .pos        (pos_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Starts a run and checks A/B, pos, busy and done every cycle against
   // exp_q (entry k = levels after step k). abort_after >= 0 raises abort
   // on the wrap that would emit step abort_after+1, and pokes start mid-run.
   task automatic apply_stimulus(input string tag, input logic d, input logic [31:0] hp_in,
                                 input logic [15:0] s, input int hp_eff, input int abort_after,
                                 input logic [31:0] pos0);
      int          n_steps;
      int          end_c;
      int          k;
      logic [31:0] exp_pos;
      n_steps = (abort_after >= 0) ? abort_after : int'(s);
      end_c   = (abort_after >= 0) ? (abort_after + 1) * hp_eff :
                ((s == 16'd0) ? 1 : int'(s) * hp_eff);
      @(negedge clk);
      dir         = d;
      half_period = hp_in;
      steps       = s;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output($sformatf("%s_c0_busy", tag), 32'(busy), 32'd1);
      check_output($sformatf("%s_c0_ab", tag), 32'({quad_a, quad_b}), 32'(exp_q[0]));
      for (int c = 1; c <= end_c + 2; c++) begin
         @(negedge clk);
         k = c / hp_eff;
         if (k > n_steps) k = n_steps;
         exp_pos = d ? pos0 + 32'(k) : pos0 - 32'(k);
         check_output($sformatf("%s_c%0d_ab", tag, c), 32'({quad_a, quad_b}), 32'(exp_q[k]));
         check_output($sformatf("%s_c%0d_pos", tag, c), pos, exp_pos);
         check_output($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'(c < end_c));
         check_output($sformatf("%s_c%0d_done", tag, c), 32'(done), 32'(c == end_c + 1));
         if (abort_after >= 0) begin
            if (c == 5) begin
               start = 1'b1;
               dir   = ~d;
               steps = 16'd3;
            end
            if (c == 6) start = 1'b0;
            if (c == end_c - 1) abort = 1'b1;
            if (c == end_c) abort = 1'b0;
         end
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      dir          = 1'b0;
      half_period  = 32'd0;
      steps        = 16'd0;
      clr_pos      = 1'b0;

      #12;
      check_output("rst_ab", 32'({quad_a, quad_b}), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_pos", pos, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] forward run hp=3 steps=8");
      exp_q = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      apply_stimulus("fwd", 1'b1, 32'd3, 16'd8, 3, -1, 32'd0);

      $display("[TB] reverse run hp=1 steps=5");
      exp_q = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
      apply_stimulus("rev", 1'b0, 32'd1, 16'd5, 1, -1, 32'd8);

      $display("[TB] zero steps");
      exp_q = '{2'b01};
      apply_stimulus("zero", 1'b1, 32'd2, 16'd0, 2, -1, 32'd3);

      $display("[TB] half_period 0 acts as 1");
      exp_q = '{2'b01, 2'b00, 2'b10, 2'b11};
      apply_stimulus("hp0", 1'b1, 32'd0, 16'd3, 1, -1, 32'd3);

      $display("[TB] abort after 3 of 10 steps");
      exp_q = '{2'b11, 2'b01, 2'b00, 2'b10};
      apply_stimulus("abort", 1'b1, 32'd4, 16'd10, 4, 3, 32'd6);

      $display("[TB] clr_pos coinciding with a step");
      @(negedge clk);
      dir         = 1'b0;
      half_period = 32'd2;
      steps       = 16'd2;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_output("clr_c1_ab", 32'({quad_a, quad_b}), 32'b10);
      clr_pos = 1'b1;
      @(negedge clk);
      clr_pos = 1'b0;
      check_output("clr_c2_ab", 32'({quad_a, quad_b}), 32'b00);
      check_output("clr_c2_pos", pos, 32'd0);
      repeat (2) @(negedge clk);
      check_output("clr_c4_ab", 32'({quad_a, quad_b}), 32'b01);
      check_output("clr_c4_pos", pos, 32'hFFFF_FFFF);
      @(negedge clk);
      check_output("clr_c5_done", 32'(done), 32'd1);

      $display("[TB] start with abort in IDLE");
      @(negedge clk);
      dir         = 1'b1;
      half_period = 32'd1;
      steps       = 16'd4;
      start       = 1'b1;
      abort       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check_output($sformatf("sa_c%0d_busy", c), 32'(busy), 32'd0);
         check_output($sformatf("sa_c%0d_done", c), 32'(done), 32'd0);
         check_output($sformatf("sa_c%0d_ab", c), 32'({quad_a, quad_b}), 32'b01);
         @(negedge clk);
      end

      $display("[TB] signed position overflow");
      clr_pos = 1'b1;
      @(negedge clk);
      clr_pos = 1'b0;
      check_output("ovf_clr_pos", pos, 32'd0);
      check_output("ovf_clr_pos_w", 32'(pos_w), 32'd0);
      exp_q = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
      apply_stimulus("ovf", 1'b1, 32'd1, 16'd8, 1, -1, 32'd0);
      check_output("ovf_pos_w", 32'(pos_w), 32'h8);
      check_output("ovf_ab_w", 32'({quad_a_w, quad_b_w}), 32'b01);
      check_output("ovf_busy_w", 32'(busy_w), 32'd0);
      check_output("ovf_done_w", 32'(done_w), 32'd0);

      $display("[TB] async reset mid-run");
      @(negedge clk);
      dir         = 1'b1;
      half_period = 32'd2;
      steps       = 16'd6;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rr_pre_ab", 32'({quad_a, quad_b}), 32'b00);
      check_output("rr_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("rr_ab", 32'({quad_a, quad_b}), 32'b00);
      check_output("rr_busy", 32'(busy), 32'd0);
      check_output("rr_pos", pos, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_output($sformatf("rr_c%0d_done", c), 32'(done), 32'd0);
         check_output($sformatf("rr_c%0d_busy", c), 32'(busy), 32'd0);
      end
      exp_q = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      apply_stimulus("post_rst", 1'b1, 32'd1, 16'd4, 1, -1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
